// File: rtl/papuf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : papuf_eval_ctrl
//  Purpose  : Evaluation controller for an array of N_BITS papuf cells that
//             share one challenge bus and one pulse line. Latches a challenge,
//             pulses the array PULSE_CYC cycles, waits SETTLE_CYC cycles,
//             samples the synchronised responses and repeats N_EVAL times.
//             Produces a per-bit majority-voted response and a per-bit
//             instability flag (votes not unanimous).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, challenge  - request strobe and challenge (IDLE only)
//             abort             - cancel the operation in progress
//             busy, done        - status; done is a one-cycle pulse
//             response,unstable - voted result, held until next done / rst
//             puf_challenge     - challenge bus to the cells
//             puf_pulse         - shared pulse line to the cells
//             puf_resp          - raw cell outputs, asynchronous to clk
//  Revision : 1.0 - initial release
// ============================================================================
module papuf_eval_ctrl #(
    parameter int N_BITS     = 16,
    parameter int CH_W       = 16,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int N_EVAL     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CH_W-1:0]   challenge,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] response,
    output logic [N_BITS-1:0] unstable,
    output logic [CH_W-1:0]   puf_challenge,
    output logic              puf_pulse,
    input  logic [N_BITS-1:0] puf_resp
);

    // Widths of the phase counter, eval counter and per-bit ones counters
    localparam int c_PH_MAX  = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int c_CNT_W   = $clog2(c_PH_MAX + 1);
    localparam int c_EV_W    = $clog2(N_EVAL + 1);
    localparam int c_ONES_W  = $clog2(N_EVAL + 1);

    localparam logic [c_CNT_W-1:0]  c_PULSE_LAST  = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_EV_W-1:0]   c_EV_LAST     = c_EV_W'(N_EVAL - 1);
    localparam logic [c_ONES_W-1:0] c_HALF        = c_ONES_W'(N_EVAL / 2);
    localparam logic [c_ONES_W-1:0] c_FULL        = c_ONES_W'(N_EVAL);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_PULSE  = 3'd1;
    localparam logic [2:0] c_SETTLE = 3'd2;
    localparam logic [2:0] c_SAMPLE = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_ph;
    logic [c_EV_W-1:0]   r_ev;
    logic [CH_W-1:0]     r_chal;
    logic [N_BITS-1:0]   r_sync1;
    logic [N_BITS-1:0]   r_sync2;

    logic w_accept;
    logic w_sample;
    logic w_last;

    assign w_accept = (r_state == c_IDLE) && start;
    // An abort landing on the SAMPLE cycle discards that sample entirely
    assign w_sample = (r_state == c_SAMPLE) && !abort;
    assign w_last   = (r_ev == c_EV_LAST);

    assign busy          = (r_state != c_IDLE);
    assign done          = (r_state == c_DONE);
    assign puf_pulse     = (r_state == c_PULSE);
    assign puf_challenge = r_chal;

    // Two-flop synchroniser for the asynchronous cell outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= puf_resp;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ph    <= '0;
            r_ev    <= '0;
            r_chal  <= '0;
        end else if (r_state == c_IDLE) begin
            if (start) begin
                r_chal  <= challenge;
                r_ev    <= '0;
                r_ph    <= '0;
                r_state <= c_PULSE;
            end
        end else if (abort) begin
            // DONE also returns to IDLE here; done is still high this cycle
            r_state <= c_IDLE;
            r_ph    <= '0;
        end else begin
            case (r_state)
                c_PULSE: begin
                    if (r_ph == c_PULSE_LAST) begin
                        r_ph    <= '0;
                        r_state <= c_SETTLE;
                    end else begin
                        r_ph <= r_ph + c_CNT_W'(1);
                    end
                end
                c_SETTLE: begin
                    if (r_ph == c_SETTLE_LAST) begin
                        r_ph    <= '0;
                        r_state <= c_SAMPLE;
                    end else begin
                        r_ph <= r_ph + c_CNT_W'(1);
                    end
                end
                c_SAMPLE: begin
                    if (w_last) begin
                        r_state <= c_DONE;
                    end else begin
                        r_ev    <= r_ev + c_EV_W'(1);
                        r_state <= c_PULSE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Per-bit vote accumulation; the result registers are loaded from the
    // next-count value so the final sample is included on entry to DONE.
    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        logic [c_ONES_W-1:0] r_ones;
        logic [c_ONES_W-1:0] w_ones_nxt;
        logic                r_resp;
        logic                r_unst;

        assign w_ones_nxt  = r_ones + c_ONES_W'(r_sync2[i]);
        assign response[i] = r_resp;
        assign unstable[i] = r_unst;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ones <= '0;
                r_resp <= 1'b0;
                r_unst <= 1'b0;
            end else if (w_accept) begin
                r_ones <= '0;
            end else if (w_sample) begin
                r_ones <= w_ones_nxt;
                if (w_last) begin
                    r_resp <= (w_ones_nxt > c_HALF);
                    r_unst <= (w_ones_nxt != '0) && (w_ones_nxt != c_FULL);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_papuf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_papuf_eval_ctrl
//  Purpose  : Self-checking bench for papuf_eval_ctrl (default parameters)
//             plus a second instance with N_EVAL=1, PULSE_CYC=1, SETTLE_CYC=2.
//             Cycle n is the clock period following rising edge n-1, where
//             edge 0 is the edge that samples start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_papuf_eval_ctrl;

    localparam int NE = 5;
    localparam int PC = 4;
    localparam int SC = 8;
    localparam int DONE_CYC = NE * (PC + SC + 1) + 1;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] challenge, puf_resp;
    logic        busy, done, puf_pulse;
    logic [15:0] response, unstable, puf_challenge;

    logic        p_start, p_abort;
    logic [15:0] p_challenge, p_resp;
    logic        p_busy, p_done, p_pulse;
    logic [15:0] p_response, p_unstable, p_pch;

    always #5 clk = ~clk;

    papuf_eval_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .challenge(challenge),
        .busy(busy), .done(done), .response(response), .unstable(unstable),
        .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_resp(puf_resp)
    );

    papuf_eval_ctrl #(.N_BITS(16), .CH_W(16), .PULSE_CYC(1), .SETTLE_CYC(2), .N_EVAL(1)) dut_p (
        .clk(clk), .rst(rst), .start(p_start), .abort(p_abort), .challenge(p_challenge),
        .busy(p_busy), .done(p_done), .response(p_response), .unstable(p_unstable),
        .puf_challenge(p_pch), .puf_pulse(p_pulse), .puf_resp(p_resp)
    );

    int errors = 0;
    int checks = 0;

    // Per-evaluation cell output vectors for the current operation
    logic [15:0] tv [NE];

    // Operation configuration
    int cfg_abort_at, cfg_rst_at;
    int cfg_starts[$];
    bit cfg_scramble, cfg_abort0;

    // Observations of the last operation
    int          done_cycles[$];
    int          widths[$];
    int          pch_bad;
    logic [15:0] done_resp, done_unst, pch1;
    logic        busy1;
    logic        s_pulse, s_busy, s_done;
    logic [15:0] s_resp, s_unst, s_pch;

    // Majority vote computed directly from the per-evaluation vectors
    function automatic logic [31:0] vote_model();
        logic [15:0] r;
        logic [15:0] u;
        int c;
        r = '0;
        u = '0;
        for (int b = 0; b < 16; b++) begin
            c = 0;
            for (int k = 0; k < NE; k++) c += int'(tv[k][b]);
            r[b] = (2 * c > NE);
            u[b] = (c != 0) && (c != NE);
        end
        return {r, u};
    endfunction

    task automatic cfg_clear();
        cfg_abort_at = -5;
        cfg_rst_at   = -5;
        cfg_starts.delete();
        cfg_scramble = 1'b0;
        cfg_abort0   = 1'b0;
    endtask

    // Starts an operation at edge 0 and observes cycles 1..limit
    task automatic drive_op(input logic [15:0] ch, input int limit);
        int pulses;
        int run;
        pulses = 0;
        run    = 0;
        pch_bad = 0;
        done_cycles.delete();
        widths.delete();
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        abort     = cfg_abort0;
        puf_resp  = tv[0];
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (cfg_scramble) challenge = 16'($urandom);
            foreach (cfg_starts[k]) if (cfg_starts[k] == n) start = 1'b1;
            if (n == cfg_abort_at) abort = 1'b1;
            if (n == cfg_rst_at) rst = 1'b1;
            if (n == 1) begin
                pch1  = puf_challenge;
                busy1 = busy;
            end
            if (busy === 1'b1 && puf_challenge !== ch) pch_bad++;
            if (puf_pulse === 1'b1) begin
                if (run == 0) begin
                    pulses++;
                    puf_resp = tv[(pulses - 1) % NE];
                end
                run++;
            end else if (run > 0) begin
                widths.push_back(run);
                run = 0;
            end
            if (done === 1'b1) begin
                done_cycles.push_back(n);
                done_resp = response;
                done_unst = unstable;
            end
            if (n == cfg_abort_at + 1 || n == cfg_rst_at + 1) begin
                s_pulse = puf_pulse;
                s_busy  = busy;
                s_done  = done;
                s_resp  = response;
                s_unst  = unstable;
                s_pch   = puf_challenge;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (puf_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", puf_pulse); end
        checks++; if (response !== 16'h0) begin errors++; $display("FAIL reset_resp: got %h want 0000", response); end
        checks++; if (unstable !== 16'h0) begin errors++; $display("FAIL reset_unst: got %h want 0000", unstable); end
        checks++; if (puf_challenge !== 16'h0) begin errors++; $display("FAIL reset_pch: got %h want 0000", puf_challenge); end
        checks++; if (p_busy !== 1'b0 || p_response !== 16'h0) begin errors++; $display("FAIL reset_param: busy %b resp %h want 0 0000", p_busy, p_response); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] e;
        for (int k = 0; k < NE; k++) tv[k] = 16'hA5A5;
        e = vote_model();
        cfg_clear();
        drive_op(16'h1234, DONE_CYC + 2);
        checks++; if (pch1 !== 16'h1234) begin errors++; $display("FAIL basic_pch: got %h want 1234", pch1); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy1: got %b want 1", busy1); end
        checks++; if (widths.size() != NE) begin errors++; $display("FAIL basic_npulses: got %0d want %0d", widths.size(), NE); end
        foreach (widths[k]) begin
            checks++; if (widths[k] != PC) begin errors++; $display("FAIL basic_pwidth%0d: got %0d want %0d", k, widths[k], PC); end
        end
        checks++; if (done_cycles.size() != 1 || done_cycles[0] != 66) begin errors++; $display("FAIL basic_done_cycle: got n=%0d first=%0d want 1 at 66", done_cycles.size(), done_cycles.size() ? done_cycles[0] : -1); end
        checks++; if (done_resp !== e[31:16] || done_resp !== 16'hA5A5) begin errors++; $display("FAIL basic_resp: got %h want a5a5", done_resp); end
        checks++; if (done_unst !== e[15:0] || done_unst !== 16'h0) begin errors++; $display("FAIL basic_unst: got %h want 0000", done_unst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_votes();
        logic [31:0] e;
        // bit0 1,1,0,1,0
        tv[0] = 16'h0001; tv[1] = 16'h0001; tv[2] = 16'h0000; tv[3] = 16'h0001; tv[4] = 16'h0000;
        e = vote_model();
        cfg_clear();
        drive_op(16'hBEEF, DONE_CYC + 2);
        checks++; if (done_resp !== 16'h0001 || done_resp !== e[31:16]) begin errors++; $display("FAIL vote_bit0_resp: got %h want 0001", done_resp); end
        checks++; if (done_unst !== 16'h0001 || done_unst !== e[15:0]) begin errors++; $display("FAIL vote_bit0_unst: got %h want 0001", done_unst); end
        // bit3 0,1,0,0,1 and bit7 always 1
        tv[0] = 16'h0080; tv[1] = 16'h0088; tv[2] = 16'h0080; tv[3] = 16'h0080; tv[4] = 16'h0088;
        e = vote_model();
        cfg_clear();
        drive_op(16'h0F0F, DONE_CYC + 2);
        checks++; if (done_resp !== 16'h0080 || done_resp !== e[31:16]) begin errors++; $display("FAIL vote_b37_resp: got %h want 0080", done_resp); end
        checks++; if (done_unst !== 16'h0008 || done_unst !== e[15:0]) begin errors++; $display("FAIL vote_b37_unst: got %h want 0008", done_unst); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [15:0] base, ch;
        for (int t = 0; t < 6; t++) begin
            base = 16'($urandom);
            for (int k = 0; k < NE; k++) tv[k] = base ^ (16'($urandom) & 16'($urandom));
            e = vote_model();
            ch = 16'($urandom);
            cfg_clear();
            cfg_scramble = 1'b1;
            drive_op(ch, DONE_CYC + 2);
            checks++; if (done_cycles.size() != 1 || done_cycles[0] != DONE_CYC) begin errors++; $display("FAIL rand%0d_done: got n=%0d want 1 at %0d", t, done_cycles.size(), DONE_CYC); end
            checks++; if (done_resp !== e[31:16]) begin errors++; $display("FAIL rand%0d_resp: got %h want %h", t, done_resp, e[31:16]); end
            checks++; if (done_unst !== e[15:0]) begin errors++; $display("FAIL rand%0d_unst: got %h want %h", t, done_unst, e[15:0]); end
            checks++; if (pch_bad != 0) begin errors++; $display("FAIL rand%0d_pch_stable: got %0d changed cycles want 0", t, pch_bad); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NE; k++) tv[k] = 16'h3C3C;
        cfg_clear();
        cfg_starts.push_back(10);
        cfg_starts.push_back(66);
        cfg_starts.push_back(67);
        drive_op(16'h5555, 2 * DONE_CYC + 6);
        checks++; if (done_cycles.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", done_cycles.size()); end
        checks++; if (done_cycles.size() != 2 || done_cycles[0] != 66 || done_cycles[1] != 133) begin errors++; $display("FAIL b2b_cycles: got %0d,%0d want 66,133", done_cycles.size() > 0 ? done_cycles[0] : -1, done_cycles.size() > 1 ? done_cycles[1] : -1); end
        checks++; if (done_resp !== 16'h3C3C) begin errors++; $display("FAIL b2b_resp: got %h want 3c3c", done_resp); end
    endtask

    task automatic test_abort();
        logic [15:0] pr, pu;
        pr = response;
        pu = unstable;
        for (int k = 0; k < NE; k++) tv[k] = ~pr;
        cfg_clear();
        cfg_abort_at = 30;
        drive_op(16'h7777, DONE_CYC + 4);
        checks++; if (s_pulse !== 1'b0) begin errors++; $display("FAIL abort_pulse: got %b want 0", s_pulse); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", s_busy); end
        checks++; if (done_cycles.size() != 0) begin errors++; $display("FAIL abort_nodone: got %0d dones want 0", done_cycles.size()); end
        checks++; if (response !== pr || unstable !== pu) begin errors++; $display("FAIL abort_hold: got %h/%h want %h/%h", response, unstable, pr, pu); end
    endtask

    task automatic test_abort_done();
        logic [31:0] e;
        tv[0] = 16'hF00F; tv[1] = 16'hF0F0; tv[2] = 16'hFF00; tv[3] = 16'hF00F; tv[4] = 16'h0FF0;
        e = vote_model();
        cfg_clear();
        cfg_abort_at = 66;
        drive_op(16'h1111, DONE_CYC + 3);
        checks++; if (done_cycles.size() != 1 || done_cycles[0] != 66) begin errors++; $display("FAIL abortdone_done: got n=%0d want 1 at 66", done_cycles.size()); end
        checks++; if (done_resp !== e[31:16] || done_unst !== e[15:0]) begin errors++; $display("FAIL abortdone_result: got %h/%h want %h/%h", done_resp, done_unst, e[31:16], e[15:0]); end
    endtask

    task automatic test_idle_abort();
        logic [15:0] pr;
        pr = response;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || response !== pr) begin errors++; $display("FAIL idle_abort: busy %b resp %h want 0 %h", busy, response, pr); end
        abort = 1'b0;
        for (int k = 0; k < NE; k++) tv[k] = 16'h1357;
        cfg_clear();
        cfg_abort0 = 1'b1;
        drive_op(16'h2468, DONE_CYC + 2);
        checks++; if (done_cycles.size() != 1 || done_cycles[0] != 66 || done_resp !== 16'h1357) begin errors++; $display("FAIL start_abort_idle: got n=%0d resp %h want 1 at 66 resp 1357", done_cycles.size(), done_resp); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < NE; k++) tv[k] = 16'hFFFF;
        cfg_clear();
        cfg_rst_at = 20;
        drive_op(16'h9999, DONE_CYC + 4);
        checks++; if (s_busy !== 1'b0 || s_pulse !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy %b pulse %b done %b want 0 0 0", s_busy, s_pulse, s_done); end
        checks++; if (s_resp !== 16'h0 || s_unst !== 16'h0 || s_pch !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h/%h want 0000/0000/0000", s_resp, s_unst, s_pch); end
        checks++; if (done_cycles.size() != 0) begin errors++; $display("FAIL rstmid_nodone: got %0d dones want 0", done_cycles.size()); end
    endtask

    task automatic test_param();
        int dc;
        int first;
        logic [15:0] r, u;
        dc = 0;
        first = -1;
        r = '0;
        u = '0;
        @(negedge clk);
        p_start     = 1'b1;
        p_challenge = 16'hABCD;
        p_resp      = 16'h00FF;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            p_start = 1'b0;
            if (p_done === 1'b1) begin
                dc++;
                if (first < 0) begin
                    first = n;
                    r = p_response;
                    u = p_unstable;
                end
            end
        end
        checks++; if (first != 1 * (1 + 2 + 1) + 1 || dc != 1) begin errors++; $display("FAIL param_done: got cycle %0d count %0d want 5 1", first, dc); end
        checks++; if (r !== 16'h00FF) begin errors++; $display("FAIL param_resp: got %h want 00ff", r); end
        checks++; if (u !== 16'h0) begin errors++; $display("FAIL param_unst: got %h want 0000", u); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; challenge = '0; puf_resp = '0;
        p_start = 1'b0; p_abort = 1'b0; p_challenge = '0; p_resp = '0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_votes();
        test_random();
        test_back_to_back();
        test_abort();
        test_abort_done();
        test_idle_abort();
        test_reset_mid();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
